// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants and types for the 7-segment display snoop path.
package seg_scan_decoder_pkg;

    // Glyphs on the active-low abcdefg bus (bit6 = a ... bit0 = g)
    localparam logic [6:0] GLYPH_0 = 7'b0000001;
    localparam logic [6:0] GLYPH_1 = 7'b1001111;
    localparam logic [6:0] GLYPH_2 = 7'b0010010;
    localparam logic [6:0] GLYPH_3 = 7'b0000110;
    localparam logic [6:0] GLYPH_4 = 7'b1001100;
    localparam logic [6:0] GLYPH_5 = 7'b0100100;
    localparam logic [6:0] GLYPH_6 = 7'b0100000;
    localparam logic [6:0] GLYPH_7 = 7'b0001111;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0000100;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_B = 7'b1100000;
    localparam logic [6:0] GLYPH_C = 7'b0110001;
    localparam logic [6:0] GLYPH_D = 7'b1000010;
    localparam logic [6:0] GLYPH_E = 7'b0110000;
    localparam logic [6:0] GLYPH_F = 7'b0111000;

    // All anodes off: display blanked
    localparam logic [3:0] BLANK_AN = 4'b1111;

    // Dwell tracker states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } scan_state_e;

    // Which digit the anode bus selects, if any
    typedef struct packed {
        logic       legal;
        logic [1:0] idx;
    } anode_sel_t;

    // Exactly one anode low selects a digit; anything else is not a digit
    function automatic anode_sel_t decode_anode(input logic [3:0] an);
        anode_sel_t sel;
        sel = '0;
        case (an)
            4'b1110: sel = '{legal: 1'b1, idx: 2'd0};
            4'b1101: sel = '{legal: 1'b1, idx: 2'd1};
            4'b1011: sel = '{legal: 1'b1, idx: 2'd2};
            4'b0111: sel = '{legal: 1'b1, idx: 2'd3};
            default: sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/seven_seg_to_hex.sv
// Combinational inverse of the active-low 7-segment hex glyph table.
module seven_seg_to_hex
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] abcdefg,
    output logic [3:0] nibble,
    output logic       legal
);

    // Map a glyph back to its hex value; unknown patterns are flagged illegal
    always_comb begin
        nibble = '0;
        legal  = 1'b1;
        case (abcdefg)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed 4-digit common-anode display bus and recovers the
// 16-bit hex value shown, flagging stable glyphs that are not hex digits.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  abcdefg,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic [3:0]  digit_mask,
    output logic        decode_err,
    output logic [1:0]  err_digit
);

    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    scan_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [10:0]      prev_q;

    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  mask_q, mask_d;
    logic        complete_q, complete_d;
    logic [15:0] value_q;
    logic        frame_valid_q;
    logic        decode_err_q;
    logic [1:0]  err_digit_q;

    anode_sel_t  sel;
    logic        same;
    logic        capture;
    logic [3:0]  nibble;
    logic        glyph_legal;

    seven_seg_to_hex u_glyph (
        .abcdefg (abcdefg),
        .nibble  (nibble),
        .legal   (glyph_legal)
    );

    // Classify the current bus sample against the previous one
    always_comb begin
        sel     = decode_anode(an);
        same    = ({an, abcdefg} == prev_q);
        capture = sel.legal && same && (state_q == ST_TRACK) && (cnt_q == CNT_LAST);
    end

    // Dwell tracker: counts consecutive identical legal samples, saturating
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prev_q  <= {BLANK_AN, 7'h7F};
        end else begin
            prev_q <= {an, abcdefg};
            if (!sel.legal) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else if (!same) begin
                state_q <= ST_TRACK;
                cnt_q   <= CNT_ONE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_TRACK;
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                    ST_TRACK: begin
                        if (capture) begin
                            state_q <= ST_HOLD;
                            cnt_q   <= CNT_SAT;
                        end else begin
                            cnt_q   <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= ST_HOLD;
                        cnt_q   <= CNT_SAT;
                    end
                endcase
            end
        end
    end

    // Next shadow/mask: a completed frame clears the mask before any new capture lands
    always_comb begin
        shadow_d   = shadow_q;
        mask_d     = complete_q ? '0 : mask_q;
        complete_d = 1'b0;
        if (capture && glyph_legal) begin
            shadow_d[{sel.idx, 2'b00} +: 4] = nibble;
            mask_d[sel.idx]                 = 1'b1;
            complete_d                      = (mask_d == 4'b1111);
        end
    end

    // Capture, frame publication and error pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q      <= '0;
            mask_q        <= '0;
            complete_q    <= 1'b0;
            value_q       <= '0;
            frame_valid_q <= 1'b0;
            decode_err_q  <= 1'b0;
            err_digit_q   <= '0;
        end else begin
            shadow_q      <= shadow_d;
            mask_q        <= mask_d;
            complete_q    <= complete_d;
            frame_valid_q <= complete_q;
            decode_err_q  <= capture && !glyph_legal;
            if (complete_q) begin
                value_q <= shadow_q;
            end
            if (capture && !glyph_legal) begin
                err_digit_q <= sel.idx;
            end
        end
    end

    assign value       = value_q;
    assign frame_valid = frame_valid_q;
    assign digit_mask  = mask_q;
    assign decode_err  = decode_err_q;
    assign err_digit   = err_digit_q;

endmodule
